// File: rtl/cordic2_pkg.sv
// Shared types and constants for the cordic2 request scheduler.
// A delay-line stage records whether an issue occupies it and which requester owns it.
package cordic2_pkg;

  localparam int FP32_W      = 32;
  localparam int CORDIC2_LAT = 16;

  typedef logic req_tag_t;

  typedef struct packed {
    logic     v;
    req_tag_t tag;
  } delay_stage_t;

endpackage

// File: rtl/cordic2_tag_pipe.sv
// Non-stallable {valid, tag} shift register that follows each issue through cordic2.
// Exposes the tail stage and a flag telling whether any stage is occupied.
module cordic2_tag_pipe
  import cordic2_pkg::*;
#(
  parameter int DEPTH = CORDIC2_LAT + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  delay_stage_t in_stage,
  output delay_stage_t tail,
  output logic         any_valid
);

  delay_stage_t stages [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
    end else begin
      stages[0] <= in_stage;
      for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
    end
  end

  always_comb begin
    any_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) any_valid = any_valid | stages[i].v;
  end

  assign tail = stages[DEPTH-1];

endmodule

// File: rtl/cordic2_sched.sv
// Round-robin scheduler sharing one free-running cordic2 pipeline between two requesters,
// with per-requester in-flight caps and tag-routed result return.
module cordic2_sched
  import cordic2_pkg::*;
#(
  parameter int CORDIC_LAT   = CORDIC2_LAT,
  parameter int MAX_INFLIGHT = 8,
  parameter int CNT_W        = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [FP32_W-1:0] req0_theta,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [FP32_W-1:0] req1_theta,
  output logic              req1_ready,
  output logic              res0_valid,
  output logic [FP32_W-1:0] res0_data,
  output logic              res1_valid,
  output logic [FP32_W-1:0] res1_data,
  output logic [FP32_W-1:0] cordic_theta,
  input  logic [FP32_W-1:0] cordic_result,
  output logic              idle
);

  logic [CNT_W-1:0]  cnt0, cnt1;
  logic              rr_last;
  logic              elig0, elig1, grant0, grant1;
  logic              retire0, retire1, pipe_busy;
  logic [FP32_W-1:0] hold0, hold1;
  delay_stage_t      issue_stage, tail;

  // Grants are suppressed while reset is held so nothing looks accepted during reset.
  always_comb begin
    issue_stage     = '0;
    elig0           = !reset && req0_valid && (cnt0 < CNT_W'(MAX_INFLIGHT));
    elig1           = !reset && req1_valid && (cnt1 < CNT_W'(MAX_INFLIGHT));
    grant0          = elig0 && (!elig1 || rr_last);
    grant1          = elig1 && (!elig0 || !rr_last);
    issue_stage.v   = grant0 || grant1;
    issue_stage.tag = grant1;
    retire0         = tail.v && (tail.tag == 1'b0);
    retire1         = tail.v && (tail.tag == 1'b1);
  end

  // One extra stage covers the operand register sitting in front of cordic2.
  cordic2_tag_pipe #(
    .DEPTH(CORDIC_LAT + 1)
  ) u_tag_pipe (
    .clk      (clk),
    .reset    (reset),
    .in_stage (issue_stage),
    .tail     (tail),
    .any_valid(pipe_busy)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cordic_theta <= '0;
      rr_last      <= 1'b1;
    end else if (grant0) begin
      cordic_theta <= req0_theta;
      rr_last      <= 1'b0;
    end else if (grant1) begin
      cordic_theta <= req1_theta;
      rr_last      <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (grant0 && !retire0)      cnt0 <= cnt0 + CNT_W'(1);
      else if (!grant0 && retire0) cnt0 <= cnt0 - CNT_W'(1);
      if (grant1 && !retire1)      cnt1 <= cnt1 + CNT_W'(1);
      else if (!grant1 && retire1) cnt1 <= cnt1 - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold0 <= '0;
      hold1 <= '0;
    end else begin
      if (retire0) hold0 <= cordic_result;
      if (retire1) hold1 <= cordic_result;
    end
  end

  // A retire with nothing outstanding would mean the tag line and counters disagree.
  always @(posedge clk) begin
    if (!reset) begin
      assert (!(retire0 && !grant0 && cnt0 == '0));
      assert (!(retire1 && !grant1 && cnt1 == '0));
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign res0_valid = retire0;
  assign res1_valid = retire1;
  assign res0_data  = retire0 ? cordic_result : hold0;
  assign res1_data  = retire1 ? cordic_result : hold1;
  assign idle       = !pipe_busy && !issue_stage.v;

endmodule

// File: tb/tb_cordic2_sched.sv
// Directed bench for cordic2_sched with a fixed-depth cordic2 stand-in and a tag scoreboard.
module tb_cordic2_sched;

  localparam int LAT = 16;
  localparam int MAXF = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [31:0] req0_theta = '0, req1_theta = '0;
  logic        req0_ready, req1_ready, res0_valid, res1_valid, idle;
  logic [31:0] res0_data, res1_data, cordic_theta, cordic_result;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  cordic2_sched #(.CORDIC_LAT(LAT), .MAX_INFLIGHT(MAXF), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_theta(req0_theta), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_theta(req1_theta), .req1_ready(req1_ready),
    .res0_valid(res0_valid), .res0_data(res0_data),
    .res1_valid(res1_valid), .res1_data(res1_data),
    .cordic_theta(cordic_theta), .cordic_result(cordic_result), .idle(idle)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] cordicModel(input logic [31:0] x);
    return {x[15:0], x[31:16]} ^ 32'h5a5a_c3c3;
  endfunction

  // cordic2 stand-in: same depth, traceable transform so each result identifies its angle.
  logic [31:0] cpipe [LAT];
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LAT; i++) cpipe[i] <= '0;
    end else begin
      cpipe[0] <= cordicModel(cordic_theta);
      for (int i = 1; i < LAT; i++) cpipe[i] <= cpipe[i-1];
    end
  end
  assign cordic_result = cpipe[LAT-1];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v0, input logic [31:0] t0,
                               input logic v1, input logic [31:0] t1);
    @(posedge clk);
    #1;
    req0_valid = v0; req0_theta = t0;
    req1_valid = v1; req1_theta = t1;
  endtask

  logic [31:0] q0[$], q1[$];
  int a0[$], a1[$];
  int out0 = 0, out1 = 0, maxOut0 = 0, wait1 = 0, maxWait1 = 0;
  int resSeen = 0, accTotal = 0;
  bit simul0 = 0;

  // Scoreboard: accepted angles queued per tag; every result must match the queue head.
  always @(negedge clk) begin
    if (reset) begin
      q0.delete(); q1.delete(); a0.delete(); a1.delete();
      out0 = 0; out1 = 0; wait1 = 0;
    end else begin
      if (req0_valid && req1_valid) checkOutput("one_ready", {31'b0, req0_ready & req1_ready}, 32'd0);
      if (req1_valid && !req1_ready && out1 < MAXF) begin
        wait1++;
        if (wait1 > maxWait1) maxWait1 = wait1;
      end else wait1 = 0;
      if (req0_valid && req0_ready) begin
        q0.push_back(req0_theta); a0.push_back(cyc); out0++; accTotal++;
        if (res0_valid) simul0 = 1;
      end
      if (req1_valid && req1_ready) begin
        q1.push_back(req1_theta); a1.push_back(cyc); out1++; accTotal++;
      end
      if (res0_valid) begin
        resSeen++;
        if (q0.size() == 0) checkOutput("res0_spurious", 32'd1, 32'd0);
        else begin
          checkOutput("res0_data", res0_data, cordicModel(q0.pop_front()));
          checkOutput("res0_latency", cyc - a0.pop_front(), LAT + 1);
          out0--;
        end
      end
      if (res1_valid) begin
        resSeen++;
        if (q1.size() == 0) checkOutput("res1_spurious", 32'd1, 32'd0);
        else begin
          checkOutput("res1_data", res1_data, cordicModel(q1.pop_front()));
          checkOutput("res1_latency", cyc - a1.pop_front(), LAT + 1);
          out1--;
        end
      end
      if (out0 > maxOut0) maxOut0 = out0;
    end
  end

  typedef struct {
    logic v0, v1, r0, r1;
  } vec_t;

  vec_t tbl [12];
  logic [31:0] th0 = 32'h4000_0000, th1 = 32'hc000_0000;
  logic v1, acc1;
  int n, nAcc, firstCyc, ninthCyc, acc18, resBefore;

  initial begin
    tbl[0]  = '{1, 1, 1, 0};
    tbl[1]  = '{1, 1, 0, 1};
    tbl[2]  = '{1, 1, 1, 0};
    tbl[3]  = '{0, 1, 0, 1};
    tbl[4]  = '{0, 1, 0, 1};
    tbl[5]  = '{1, 1, 1, 0};
    tbl[6]  = '{1, 0, 1, 0};
    tbl[7]  = '{1, 1, 0, 1};
    tbl[8]  = '{0, 0, 0, 0};
    tbl[9]  = '{1, 1, 1, 0};
    tbl[10] = '{0, 0, 0, 0};
    tbl[11] = '{0, 1, 0, 1};

    // Reset state.
    repeat (2) @(negedge clk);
    checkOutput("rst_cordic_theta", cordic_theta, 32'd0);
    checkOutput("rst_res0_valid", {31'b0, res0_valid}, 32'd0);
    checkOutput("rst_res1_valid", {31'b0, res1_valid}, 32'd0);
    checkOutput("rst_res0_data", res0_data, 32'd0);
    checkOutput("rst_res1_data", res1_data, 32'd0);
    checkOutput("rst_idle", {31'b0, idle}, 32'd1);
    @(posedge clk); #1 reset = 1'b0;

    // Single issue.
    applyStimulus(1, 32'h3f00_0000, 0, 32'd0);
    @(negedge clk);
    checkOutput("t1_ready", {31'b0, req0_ready}, 32'd1);
    applyStimulus(0, 32'd0, 0, 32'd0);
    for (n = 1; n <= 30; n++) begin
      if (n > 1) @(negedge clk);
      else @(negedge clk);
      if (res0_valid) break;
    end
    checkOutput("t1_latency", n, LAT + 1);
    checkOutput("t1_data", res0_data, cordicModel(32'h3f00_0000));
    @(negedge clk);
    checkOutput("t1_idle_after", {31'b0, idle}, 32'd1);
    checkOutput("t1_data_hold", res0_data, cordicModel(32'h3f00_0000));

    // Arbitration table from a fresh reset (req0 wins the first tie).
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(tbl[i].v0, th0, tbl[i].v1, th1);
      @(negedge clk);
      checkOutput($sformatf("tbl%0d_ready0", i), {31'b0, req0_ready}, {31'b0, tbl[i].r0});
      checkOutput($sformatf("tbl%0d_ready1", i), {31'b0, req1_ready}, {31'b0, tbl[i].r1});
      checkOutput($sformatf("tbl%0d_idle", i), {31'b0, idle}, 32'd0);
      if (req0_ready) th0 = th0 + 1;
      if (req1_ready) th1 = th1 + 1;
    end
    applyStimulus(0, th0, 0, th1);
    repeat (25) @(negedge clk);
    checkOutput("tbl_drained", q0.size() + q1.size(), 32'd0);

    // In-flight cap on req0.
    maxOut0 = 0; simul0 = 0; nAcc = 0; firstCyc = -1; ninthCyc = -1; acc18 = 0;
    for (n = 0; n < 60; n++) begin
      applyStimulus(1, th0, 0, th1);
      @(negedge clk);
      if (req0_ready) begin
        if (nAcc == 0) firstCyc = n;
        if (nAcc == 8) ninthCyc = n;
        nAcc++;
        th0 = th0 + 1;
      end
      if (n == 17) acc18 = nAcc;
    end
    checkOutput("t3_accepts_before_retire", acc18, 8);
    checkOutput("t3_first_reaccept", ninthCyc - firstCyc, LAT + 2);
    checkOutput("t3_max_inflight", maxOut0, MAXF);
    checkOutput("t3_retire_plus_grant", {31'b0, simul0}, 32'd1);
    applyStimulus(0, th0, 0, th1);
    repeat (25) @(negedge clk);
    checkOutput("t3_drained", q0.size(), 32'd0);

    // Reset with five issues in flight.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, th0, 0, th1);
      @(negedge clk);
      checkOutput("t4_issue_ready", {31'b0, req0_ready}, 32'd1);
      th0 = th0 + 1;
    end
    applyStimulus(0, th0, 0, th1);
    @(posedge clk);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    checkOutput("t4_rst_res0_valid", {31'b0, res0_valid}, 32'd0);
    checkOutput("t4_rst_res0_data", res0_data, 32'd0);
    checkOutput("t4_rst_theta", cordic_theta, 32'd0);
    checkOutput("t4_rst_idle", {31'b0, idle}, 32'd1);
    @(posedge clk);
    @(posedge clk); #1 reset = 1'b0;
    resBefore = resSeen;
    repeat (25) @(negedge clk);
    checkOutput("t4_dropped_results", resSeen - resBefore, 32'd0);
    applyStimulus(1, th0, 1, th1);
    @(negedge clk);
    checkOutput("t4_tie_ready0", {31'b0, req0_ready}, 32'd1);
    checkOutput("t4_tie_ready1", {31'b0, req1_ready}, 32'd0);
    th0 = th0 + 1;
    applyStimulus(0, th0, 0, th1);
    repeat (25) @(negedge clk);

    // Saturating req0 against a stall-holding req1.
    maxWait1 = 0; v1 = 0; acc1 = 0;
    resBefore = resSeen - accTotal;
    for (n = 0; n < 1000; n++) begin
      v1 = (v1 && !acc1) ? 1'b1 : ($urandom_range(3) == 0);
      applyStimulus(1, th0, v1, th1);
      @(negedge clk);
      acc1 = req1_valid && req1_ready;
      if (req0_ready) th0 = th0 + 1;
      if (acc1) th1 = th1 + 1;
    end
    applyStimulus(0, th0, 0, th1);
    repeat (30) @(negedge clk);
    checkOutput("t5_req1_wait_le1", {31'b0, maxWait1 <= 1}, 32'd1);
    checkOutput("t5_q0_empty", q0.size(), 32'd0);
    checkOutput("t5_q1_empty", q1.size(), 32'd0);
    checkOutput("t5_idle_end", {31'b0, idle}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
